// File: rtl/tl_bus_arbiter.sv
// Two-master, one-slave TileLink-UL arbiter with round-robin grant.
// The grant is held for the whole transaction (all A beats, then all D beats).
module tl_bus_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_LGSIZE = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_a_valid,
  output logic                m0_a_ready,
  input  logic [2:0]          m0_a_opcode,
  input  logic [2:0]          m0_a_size,
  input  logic [ADDR_W-1:0]   m0_a_address,
  input  logic [DATA_W-1:0]   m0_a_data,
  input  logic [DATA_W/8-1:0] m0_a_mask,
  output logic                m0_d_valid,
  input  logic                m0_d_ready,
  output logic [2:0]          m0_d_opcode,
  output logic [2:0]          m0_d_size,
  output logic [DATA_W-1:0]   m0_d_data,
  input  logic                m1_a_valid,
  output logic                m1_a_ready,
  input  logic [2:0]          m1_a_opcode,
  input  logic [2:0]          m1_a_size,
  input  logic [ADDR_W-1:0]   m1_a_address,
  input  logic [DATA_W-1:0]   m1_a_data,
  input  logic [DATA_W/8-1:0] m1_a_mask,
  output logic                m1_d_valid,
  input  logic                m1_d_ready,
  output logic [2:0]          m1_d_opcode,
  output logic [2:0]          m1_d_size,
  output logic [DATA_W-1:0]   m1_d_data,
  output logic                s_a_valid,
  input  logic                s_a_ready,
  output logic [2:0]          s_a_opcode,
  output logic [2:0]          s_a_size,
  output logic [ADDR_W-1:0]   s_a_address,
  output logic [DATA_W-1:0]   s_a_data,
  output logic [DATA_W/8-1:0] s_a_mask,
  input  logic                s_d_valid,
  output logic                s_d_ready,
  input  logic [2:0]          s_d_opcode,
  input  logic [2:0]          s_d_size,
  input  logic [DATA_W-1:0]   s_d_data
);

  typedef enum logic [1:0] {IDLE, A_PHASE, D_PHASE} state_e;

  localparam logic [2:0] OP_GET = 3'd4;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [3:0] beats_left_q, beats_left_d;
  logic       is_put_q, is_put_d;

  // Oversized requests are clamped to the largest supported line.
  function automatic logic [3:0] beat_count(input logic [2:0] size);
    logic [2:0] sz;
    sz = (int'(size) > MAX_LGSIZE) ? 3'(MAX_LGSIZE) : size;
    if (sz <= 3'd3) return 4'd1;
    return 4'(1 << (sz - 3'd3));
  endfunction

  logic                own_a_valid;
  logic [2:0]          own_a_opcode;
  logic [2:0]          own_a_size;
  logic [ADDR_W-1:0]   own_a_address;
  logic [DATA_W-1:0]   own_a_data;
  logic [DATA_W/8-1:0] own_a_mask;
  logic                own_d_ready;
  logic                gnt;
  logic [2:0]          gnt_opcode;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    is_put_d     = is_put_q;

    m0_a_ready  = 1'b0;
    m1_a_ready  = 1'b0;
    m0_d_valid  = 1'b0;
    m1_d_valid  = 1'b0;
    m0_d_opcode = '0;
    m1_d_opcode = '0;
    m0_d_size   = '0;
    m1_d_size   = '0;
    m0_d_data   = '0;
    m1_d_data   = '0;
    s_a_valid   = 1'b0;
    s_a_opcode  = '0;
    s_a_size    = '0;
    s_a_address = '0;
    s_a_data    = '0;
    s_a_mask    = '0;
    s_d_ready   = 1'b0;

    own_a_valid   = owner_q ? m1_a_valid   : m0_a_valid;
    own_a_opcode  = owner_q ? m1_a_opcode  : m0_a_opcode;
    own_a_size    = owner_q ? m1_a_size    : m0_a_size;
    own_a_address = owner_q ? m1_a_address : m0_a_address;
    own_a_data    = owner_q ? m1_a_data    : m0_a_data;
    own_a_mask    = owner_q ? m1_a_mask    : m0_a_mask;
    own_d_ready   = owner_q ? m1_d_ready   : m0_d_ready;

    // A lone requester wins outright; a tie goes to the round-robin pointer.
    gnt        = (m0_a_valid && m1_a_valid) ? rr_ptr_q : m1_a_valid;
    gnt_opcode = gnt ? m1_a_opcode : m0_a_opcode;

    case (state_q)
      IDLE: begin
        if (m0_a_valid || m1_a_valid) begin
          owner_d      = gnt;
          beats_left_d = beat_count(gnt ? m1_a_size : m0_a_size);
          is_put_d     = (gnt_opcode == 3'd0) || (gnt_opcode == 3'd1);
          state_d      = A_PHASE;
        end
      end
      A_PHASE: begin
        s_a_valid   = own_a_valid;
        s_a_opcode  = own_a_opcode;
        s_a_size    = own_a_size;
        s_a_address = own_a_address;
        s_a_data    = own_a_data;
        s_a_mask    = own_a_mask;
        m0_a_ready  = !owner_q && s_a_ready;
        m1_a_ready  = owner_q && s_a_ready;
        if (own_a_valid && s_a_ready) begin
          if (is_put_q) begin
            if (beats_left_q <= 4'd1) begin
              beats_left_d = 4'd1;
              state_d      = D_PHASE;
            end else begin
              beats_left_d = beats_left_q - 4'd1;
            end
          end else if (own_a_opcode == OP_GET) begin
            state_d = D_PHASE;
          end else begin
            beats_left_d = 4'd1;
            state_d      = D_PHASE;
          end
        end
      end
      D_PHASE: begin
        s_d_ready   = own_d_ready;
        m0_d_valid  = !owner_q && s_d_valid;
        m1_d_valid  = owner_q && s_d_valid;
        m0_d_opcode = owner_q ? 3'd0 : s_d_opcode;
        m1_d_opcode = owner_q ? s_d_opcode : 3'd0;
        m0_d_size   = owner_q ? 3'd0 : s_d_size;
        m1_d_size   = owner_q ? s_d_size : 3'd0;
        m0_d_data   = owner_q ? '0 : s_d_data;
        m1_d_data   = owner_q ? s_d_data : '0;
        if (s_d_valid && own_d_ready) begin
          if (beats_left_q <= 4'd1) begin
            beats_left_d = 4'd0;
            rr_ptr_d     = ~owner_q;
            state_d      = IDLE;
          end else begin
            beats_left_d = beats_left_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      beats_left_q <= 4'd0;
      is_put_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      is_put_q     <= is_put_d;
    end
  end

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Bench for tl_bus_arbiter: bench-side masters and slave drive whole transactions,
// expectations come from a transaction-level model of grant order and beat counts.
module tb_tl_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_a_valid, m0_a_ready, m0_d_valid, m0_d_ready;
  logic [2:0]  m0_a_opcode, m0_a_size, m0_d_opcode, m0_d_size;
  logic [63:0] m0_a_address, m0_a_data, m0_d_data;
  logic [7:0]  m0_a_mask;
  logic        m1_a_valid, m1_a_ready, m1_d_valid, m1_d_ready;
  logic [2:0]  m1_a_opcode, m1_a_size, m1_d_opcode, m1_d_size;
  logic [63:0] m1_a_address, m1_a_data, m1_d_data;
  logic [7:0]  m1_a_mask;
  logic        s_a_valid, s_a_ready, s_d_valid, s_d_ready;
  logic [2:0]  s_a_opcode, s_a_size, s_d_opcode, s_d_size;
  logic [63:0] s_a_address, s_a_data, s_d_data;
  logic [7:0]  s_a_mask;

  tl_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_size(m0_a_size), .m0_a_address(m0_a_address), .m0_a_data(m0_a_data),
    .m0_a_mask(m0_a_mask), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m0_d_opcode(m0_d_opcode), .m0_d_size(m0_d_size), .m0_d_data(m0_d_data),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_size(m1_a_size), .m1_a_address(m1_a_address), .m1_a_data(m1_a_data),
    .m1_a_mask(m1_a_mask), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .m1_d_opcode(m1_d_opcode), .m1_d_size(m1_d_size), .m1_d_data(m1_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_size(s_a_size), .s_a_address(s_a_address), .s_a_data(s_a_data),
    .s_a_mask(s_a_mask), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .s_d_opcode(s_d_opcode), .s_d_size(s_d_size), .s_d_data(s_d_data)
  );

  int compared   = 0;
  int mismatched = 0;
  int model_rr   = 0;

  logic        req_valid[2];
  logic [2:0]  req_op[2];
  logic [2:0]  req_size[2];
  logic [63:0] req_addr[2];
  logic [63:0] req_data[2];
  logic [7:0]  req_mask[2];
  logic [63:0] put_data[2][8];
  logic [2:0]  op_pool[6] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transfer size in bytes divided into 8-byte beats, never fewer than one beat.
  function automatic int refBeats(input logic [2:0] size);
    int bytes;
    bytes = 2 ** ((size > 3'd6) ? 6 : int'(size));
    return (bytes < 8) ? 1 : bytes / 8;
  endfunction

  function automatic bit isPut(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1);
  endfunction

  task automatic driveMasters();
    m0_a_valid = req_valid[0]; m0_a_opcode = req_op[0]; m0_a_size = req_size[0];
    m0_a_address = req_addr[0]; m0_a_data = req_data[0]; m0_a_mask = req_mask[0];
    m1_a_valid = req_valid[1]; m1_a_opcode = req_op[1]; m1_a_size = req_size[1];
    m1_a_address = req_addr[1]; m1_a_data = req_data[1]; m1_a_mask = req_mask[1];
  endtask

  task automatic setRequest(input int m, input logic [2:0] op, input logic [2:0] size,
                            input logic [63:0] addr);
    req_valid[m] = 1'b1;
    req_op[m]    = op;
    req_size[m]  = size;
    req_addr[m]  = addr;
    req_mask[m]  = 8'($urandom);
    for (int i = 0; i < 8; i++) put_data[m][i] = {$urandom, $urandom};
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {m0_a_ready, m0_d_valid, m1_a_ready, m1_d_valid, s_a_valid,
                 s_d_ready, m0_d_opcode, m0_d_size, m1_d_opcode, m1_d_size, s_a_opcode,
                 s_a_size, s_a_mask}, 64'd0);
    checkOutput({tag, "_s_a_address"}, s_a_address, 64'd0);
    checkOutput({tag, "_s_a_data"}, s_a_data, 64'd0);
    checkOutput({tag, "_m0_d_data"}, m0_d_data, 64'd0);
    checkOutput({tag, "_m1_d_data"}, m1_d_data, 64'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    driveMasters();
    s_a_ready = 1'b1; s_d_valid = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAllZero("reset");
    model_rr = 0;
  endtask

  // Runs one transaction starting in an IDLE cycle; abort_after>0 stops after that many D beats.
  task automatic applyStimulus(input int d_mode, input bit a_bp, input int abort_after);
    int owner, a_n, d_n, a_done, d_done, guard;
    bit get, put, tog;
    logic dr;
    logic [63:0] exp_d[$];
    @(negedge clk);
    s_d_valid = 1'b0;
    s_a_ready = 1'($urandom_range(0, 1));
    driveMasters();
    #1;
    checkOutput("idle_outputs", {m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_a_valid,
                s_d_ready}, 64'd0);
    owner = (req_valid[0] && req_valid[1]) ? model_rr : (req_valid[1] ? 1 : 0);
    get = (req_op[owner] == 3'd4);
    put = isPut(req_op[owner]);
    a_n = put ? refBeats(req_size[owner]) : 1;
    d_n = get ? refBeats(req_size[owner]) : 1;

    a_done = 0; guard = 0;
    while (a_done < a_n && guard < 200) begin
      @(negedge clk);
      req_data[owner] = put_data[owner][a_done];
      driveMasters();
      s_a_ready = a_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checkOutput("s_a_valid", s_a_valid, 64'd1);
      checkOutput("s_a_address", s_a_address, req_addr[owner]);
      checkOutput("s_a_data", s_a_data, put_data[owner][a_done]);
      checkOutput("s_a_fields", {s_a_opcode, s_a_size, s_a_mask}, {req_op[owner], req_size[owner], req_mask[owner]});
      checkOutput("owner_a_ready", owner ? m1_a_ready : m0_a_ready, s_a_ready);
      checkOutput("other_a_ready", owner ? m0_a_ready : m1_a_ready, 64'd0);
      checkOutput("s_d_ready_a", s_d_ready, 64'd0);
      if (s_a_ready) a_done++;
      guard++;
    end
    checkOutput("a_beats", a_done, a_n);
    req_valid[owner] = 1'b0;

    for (int i = 0; i < d_n; i++) exp_d.push_back({$urandom, $urandom});
    d_done = 0; guard = 0; tog = 1'b1;
    while (d_done < d_n && guard < 400) begin
      @(negedge clk);
      driveMasters();
      s_a_ready  = 1'b1;
      s_d_valid  = (d_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_d_data   = exp_d[d_done];
      s_d_opcode = get ? 3'd1 : 3'd0;
      s_d_size   = req_size[owner];
      dr = (d_mode == 1) ? tog : ((d_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      tog = ~tog;
      if (owner == 1) begin m1_d_ready = dr; m0_d_ready = 1'($urandom_range(0, 1)); end
      else begin m0_d_ready = dr; m1_d_ready = 1'($urandom_range(0, 1)); end
      #1;
      checkOutput("owner_d_valid", owner ? m1_d_valid : m0_d_valid, s_d_valid);
      checkOutput("other_d_valid", owner ? m0_d_valid : m1_d_valid, 64'd0);
      checkOutput("s_d_ready", s_d_ready, dr);
      checkOutput("s_a_valid_d", s_a_valid, 64'd0);
      if (s_d_valid) begin
        checkOutput("d_data", owner ? m1_d_data : m0_d_data, exp_d[d_done]);
        checkOutput("d_op_size", owner ? {m1_d_opcode, m1_d_size} : {m0_d_opcode, m0_d_size},
                    {(get ? 3'd1 : 3'd0), req_size[owner]});
      end
      if (s_d_valid && dr) begin
        d_done++;
        if (abort_after != 0 && d_done == abort_after) break;
      end
      guard++;
    end
    checkOutput("d_beats", d_done, (abort_after != 0) ? abort_after : d_n);
    if (abort_after == 0) model_rr = 1 - owner;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req_valid[m] = 1'b0; req_op[m] = 3'd4; req_size[m] = 3'd0;
      req_addr[m] = 64'd0; req_data[m] = 64'd0; req_mask[m] = 8'd0;
    end
    s_d_opcode = 3'd0; s_d_size = 3'd0; s_d_data = 64'd0;
    driveMasters();
    doReset();

    $display("[TB] m0 Get size 6, eight beats");
    setRequest(0, 3'd4, 3'd6, 64'h1000);
    applyStimulus(0, 1'b0, 0);

    $display("[TB] simultaneous requests, alternating grants");
    doReset();
    setRequest(0, 3'd4, 3'd3, 64'h2000);
    setRequest(1, 3'd4, 3'd3, 64'h3000);
    applyStimulus(0, 1'b0, 0);
    setRequest(0, 3'd4, 3'd3, 64'h2008);
    applyStimulus(0, 1'b0, 0);
    setRequest(1, 3'd4, 3'd3, 64'h3008);
    applyStimulus(0, 1'b0, 0);
    applyStimulus(0, 1'b0, 0);

    $display("[TB] m1 PutFullData size 4");
    setRequest(1, 3'd0, 3'd4, 64'h4000);
    put_data[1][0] = 64'hA5A5_A5A5_A5A5_A5A5;
    put_data[1][1] = 64'h5A5A_5A5A_5A5A_5A5A;
    applyStimulus(0, 1'b0, 0);

    $display("[TB] D backpressure toggling");
    setRequest(0, 3'd4, 3'd6, 64'h5000);
    applyStimulus(1, 1'b0, 0);

    $display("[TB] reset after third D beat");
    setRequest(0, 3'd4, 3'd6, 64'h6000);
    applyStimulus(0, 1'b0, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_d_valid = 1'b1;
    #1;
    checkAllZero("abort");
    model_rr = 0;
    setRequest(1, 3'd4, 3'd6, 64'h7000);
    applyStimulus(0, 1'b0, 0);

    $display("[TB] m0 Get size 2");
    setRequest(0, 3'd4, 3'd2, 64'h8000);
    applyStimulus(0, 1'b0, 0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      for (int m = 0; m < 2; m++)
        if (!req_valid[m] && $urandom_range(0, 2) != 0)
          setRequest(m, op_pool[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                     {4'(m), 28'd0, $urandom});
      if (!req_valid[0] && !req_valid[1])
        setRequest(0, 3'd4, 3'($urandom_range(0, 7)), {32'd0, $urandom});
      applyStimulus(2, 1'b1, 0);
    end
    while (req_valid[0] || req_valid[1]) applyStimulus(0, 1'b0, 0);

    @(negedge clk);
    s_d_valid = 1'b0;
    #1;
    checkOutput("final_idle", {m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_a_valid,
                s_d_ready}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
